move_dispatcher: RTL and testbench

- Buffers packed Rubik's-cube move sequences and issues them one at a time to the stepper driver (move_to_step) over a start/done handshake.
- Inserts a mechanical settle gap between moves, supports pause and abort, and detects stalled moves with a timeout.
- Sits between the sequencer/solver and the stepper driver.

---
 rtl/move_dispatcher.sv | 229 ++++++++++++++++++++++
 tb/tb_move_dispatcher.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_dispatcher.sv
// move_dispatcher: buffers packed 4-bit cube move codes and hands them one at
// a time to the stepper driver over a start/done handshake. A mechanical
// settle gap follows every move, and a timeout flags stalled moves.
// An unpacker FSM feeds a move FIFO, which a dispatcher FSM drains.
module move_dispatcher #(
    parameter int DEPTH          = 64,
    parameter int SETTLE_CYCLES  = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [199:0]             load_moves,
    output logic                     load_ready,
    input  logic                     go,
    input  logic                     pause,
    input  logic                     abort,
    output logic [3:0]               move_code,
    output logic                     move_start,
    input  logic                     move_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [7:0]               moves_issued,
    output logic                     all_done,
    output logic                     fault,
    output logic                     bad_code
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TLAST = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SLAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic {U_IDLE, U_RUN} ustate_t;
    typedef enum logic [2:0] {D_IDLE, D_ISSUE, D_WAIT, D_SETTLE, D_FAULT} dstate_t;

    ustate_t ustate;
    dstate_t dstate;

    // FIFO storage
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;

    // Unpacker state
    logic [199:0]  batch;
    logic [5:0]    idx;
    logic [3:0]    nib;
    logic          nib_zero;
    logic          nib_legal;
    logic          nib_bad;

    // Dispatcher state
    logic          armed;
    logic          done_d;
    logic          done_rise;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;

    logic          accept;
    logic          push;
    logic          pop;
    logic          advance;
    logic          adone_cond;

    assign fifo_full   = (count == (AW+1)'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign queue_count = count;

    assign load_ready  = (ustate == U_IDLE);
    assign busy        = (dstate == D_ISSUE) || (dstate == D_WAIT) || (dstate == D_SETTLE);

    assign nib       = batch[{idx, 2'b00} +: 4];
    assign nib_zero  = (nib == 4'd0);
    assign nib_legal = (nib >= 4'd2) && (nib <= 4'd13);
    assign nib_bad   = !nib_zero && !nib_legal;

    // abort overrides acceptance, pushes and pops in the same clock
    assign accept  = load_valid && load_ready && !abort;
    assign push    = (ustate == U_RUN) && nib_legal && !fifo_full && !abort;
    assign pop     = (dstate == D_IDLE) && armed && !pause && !fault && !fifo_empty && !abort;
    // a legal code facing a full FIFO holds the index until space frees up
    assign advance = (ustate == U_RUN) && !nib_zero && !(nib_legal && fifo_full);

    assign done_rise  = move_done && !done_d;
    assign adone_cond = armed && (dstate == D_IDLE) && fifo_empty &&
                        (ustate == U_IDLE) && (moves_issued != '0);

    // Unpacker: walks the latched batch one nibble per clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ustate   <= U_IDLE;
            batch    <= '0;
            idx      <= '0;
            bad_code <= 1'b0;
        end else if (abort) begin
            ustate <= U_IDLE;
        end else begin
            case (ustate)
                U_IDLE: begin
                    if (accept) begin
                        batch  <= load_moves;
                        idx    <= '0;
                        ustate <= U_RUN;
                    end
                end
                U_RUN: begin
                    if (nib_bad)
                        bad_code <= 1'b1;
                    if (nib_zero) begin
                        ustate <= U_IDLE;
                    end else if (advance) begin
                        if (idx == 6'd49)
                            ustate <= U_IDLE;
                        else
                            idx <= idx + 6'd1;
                    end
                end
                default: ustate <= U_IDLE;
            endcase
        end
    end

    // FIFO storage write port; contents need no reset
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= nib;
    end

    // FIFO pointers and occupancy; abort flushes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Dispatcher FSM with arming, issue counting and completion pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dstate       <= D_IDLE;
            move_code    <= '0;
            move_start   <= 1'b0;
            tcnt         <= '0;
            scnt         <= '0;
            fault        <= 1'b0;
            done_d       <= 1'b0;
            armed        <= 1'b0;
            moves_issued <= '0;
            all_done     <= 1'b0;
        end else begin
            done_d     <= move_done;
            move_start <= 1'b0;
            all_done   <= 1'b0;

            if (abort) begin
                armed <= 1'b0;
            end else if (adone_cond) begin
                armed    <= 1'b0;
                all_done <= 1'b1;
            end else if (go) begin
                armed <= 1'b1;
            end

            if (abort || accept)
                moves_issued <= '0;
            else if ((dstate == D_ISSUE) && (moves_issued != 8'hFF))
                moves_issued <= moves_issued + 8'd1;

            case (dstate)
                D_IDLE: begin
                    if (pop) begin
                        move_code  <= mem[rd_ptr];
                        move_start <= 1'b1;
                        dstate     <= D_ISSUE;
                    end
                end
                D_ISSUE: begin
                    // the issue clock counts as the first elapsed clock, so the
                    // fault lands exactly TIMEOUT_CYCLES clocks after the start
                    tcnt   <= TW'(1);
                    dstate <= D_WAIT;
                end
                D_WAIT: begin
                    if (done_rise) begin
                        scnt   <= '0;
                        dstate <= D_SETTLE;
                    end else if (tcnt == TW'(TLAST)) begin
                        fault  <= 1'b1;
                        dstate <= D_FAULT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                D_SETTLE: begin
                    if ((SETTLE_CYCLES == 0) || (scnt == SW'(SLAST)))
                        dstate <= D_IDLE;
                    else
                        scnt <= scnt + SW'(1);
                end
                D_FAULT: begin
                    if (abort)
                        dstate <= D_IDLE;
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_dispatcher.sv
// Testbench for move_dispatcher: directed scenarios plus randomized batches,
// checked by a scoreboard of expected move codes fed from a reference model.
module tb_move_dispatcher;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [199:0] load_moves = '0;
    logic         load_ready;
    logic         go = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   move_code;
    logic         move_start;
    logic         move_done = 1'b0;
    logic         busy;
    logic [4:0]   queue_count;
    logic [7:0]   moves_issued;
    logic         all_done;
    logic         fault;
    logic         bad_code;

    move_dispatcher #(
        .DEPTH(16),
        .SETTLE_CYCLES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid),
        .load_moves(load_moves), .load_ready(load_ready), .go(go),
        .pause(pause), .abort(abort), .move_code(move_code),
        .move_start(move_start), .move_done(move_done), .busy(busy),
        .queue_count(queue_count), .moves_issued(moves_issued),
        .all_done(all_done), .fault(fault), .bad_code(bad_code)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int expq[$];
    int starts = 0;
    int adone = 0;
    int last_start = 0;
    int gap = 0;
    int exp_issued = -1;
    bit exp_bad = 1'b0;
    bit drv_respond = 1'b1;
    int drv_delay = 10;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on every start and checks completion pulses
    always @(negedge clock) begin
        if (!reset) begin
            if (move_start) begin
                gap = cyc - last_start;
                last_start = cyc;
                starts++;
                if (expq.size() == 0)
                    fail_now("unexpected move_start");
                else
                    check("move_code", int'(move_code), expq.pop_front());
            end
            if (all_done) begin
                adone++;
                check("queue_count at all_done", int'(queue_count), 0);
                if (exp_issued >= 0)
                    check("moves_issued at all_done", int'(moves_issued), exp_issued);
            end
        end
    end

    // Stepper driver model: raises move_done drv_delay clocks after a start
    initial begin
        forever begin
            @(negedge clock);
            if (move_start && drv_respond && !reset) begin
                repeat (drv_delay) @(posedge clock);
                #1 move_done = 1'b1;
                repeat (2) @(posedge clock);
                #1 move_done = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        cycles(1);
        go = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        expq.delete();
    endtask

    // Reference model of the unpacker plus the load handshake
    task automatic load_batch(input logic [199:0] v, output int cnt);
        int  b;
        int  c;
        logic r;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            c = int'(v[i*4 +: 4]);
            if (c == 0) break;
            if (c >= 2 && c <= 13) begin
                expq.push_back(c);
                cnt++;
            end else begin
                exp_bad = 1'b1;
            end
        end
        load_moves = v;
        load_valid = 1'b1;
        b = 400;
        do begin
            @(negedge clock);
            r = load_ready;
            @(posedge clock);
            b--;
        end while (!r && b > 0);
        #1 load_valid = 1'b0;
        if (!r) fail_now("load handshake timeout");
    endtask

    task automatic wait_starts(input int target, input int budget);
        int b = budget;
        while (starts < target && b > 0) begin
            @(negedge clock);
            b--;
        end
        if (starts < target) fail_now("timeout waiting for move_start");
    endtask

    task automatic wait_done(input int prev, input int budget);
        int b = budget;
        while (adone <= prev && b > 0) begin
            @(negedge clock);
            b--;
        end
        if (adone <= prev) fail_now("timeout waiting for all_done");
        check("moves left undispatched", expq.size(), 0);
        cycles(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " load_ready"}, int'(load_ready), 1);
        check({tag, " move_start"}, int'(move_start), 0);
        check({tag, " move_code"}, int'(move_code), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " queue_count"}, int'(queue_count), 0);
        check({tag, " moves_issued"}, int'(moves_issued), 0);
        check({tag, " all_done"}, int'(all_done), 0);
        check({tag, " fault"}, int'(fault), 0);
        check({tag, " bad_code"}, int'(bad_code), 0);
    endtask

    function automatic logic [3:0] rand_legal();
        return 4'($urandom_range(2, 13));
    endfunction

    function automatic logic [3:0] rand_any();
        int sel;
        int k;
        sel = $urandom_range(0, 3);
        if (sel != 0) return rand_legal();
        k = $urandom_range(0, 3);
        case (k)
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    initial begin
        logic [199:0] v;
        int cnt, cnt2, base, prev, t0, b, len, len2;

        cycles(3);
        check_reset_outputs("in reset");
        reset = 1'b0;
        cycles(1);
        check_reset_outputs("after reset");

        // Two-move batch: order, start spacing, single all_done
        v = '0;
        v[3:0] = 4'd2;
        v[7:4] = 4'd3;
        drv_delay = 10;
        base = starts;
        prev = adone;
        load_batch(v, cnt);
        exp_issued = 2;
        pulse_go();
        wait_done(prev, 500);
        cycles(20);
        check("two-move start count", starts - base, 2);
        check("start-to-start gap", gap, 16);
        check("two-move all_done count", adone - prev, 1);
        check("two-move moves_issued", int'(moves_issued), 2);

        // 50 legal codes stall the unpacker at a full FIFO, then all drain
        v = '0;
        for (int i = 0; i < 50; i++) v[i*4 +: 4] = rand_legal();
        drv_delay = 2;
        base = starts;
        prev = adone;
        load_batch(v, cnt);
        exp_issued = 50;
        cycles(60);
        check("stalled queue_count", int'(queue_count), 16);
        check("stalled load_ready", int'(load_ready), 0);
        check("no start without go", starts - base, 0);
        pulse_go();
        wait_done(prev, 3000);
        check("50-move start count", starts - base, 50);

        // Illegal codes are skipped and flagged
        check("bad_code before illegal", int'(bad_code), 0);
        v = '0;
        v[3:0]   = 4'd2;
        v[7:4]   = 4'd14;
        v[11:8]  = 4'd5;
        v[15:12] = 4'd1;
        v[19:16] = 4'd7;
        prev = adone;
        load_batch(v, cnt);
        exp_issued = 3;
        pulse_go();
        wait_done(prev, 500);
        check("bad_code after illegal", int'(bad_code), 1);

        // Pause during the second move holds off the third
        v = '0;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = rand_legal();
        drv_delay = 6;
        base = starts;
        prev = adone;
        load_batch(v, cnt);
        exp_issued = 4;
        pulse_go();
        wait_starts(base + 2, 300);
        cycles(1);
        pause = 1'b1;
        cycles(40);
        check("paused start count", starts - base, 2);
        check("paused busy", int'(busy), 0);
        check("paused queue_count", int'(queue_count), 2);
        pause = 1'b0;
        wait_done(prev, 500);
        check("resumed start count", starts - base, 4);

        // Abort during a move with five queued
        v = '0;
        for (int i = 0; i < 6; i++) v[i*4 +: 4] = rand_legal();
        drv_delay = 12;
        base = starts;
        prev = adone;
        exp_issued = -1;
        load_batch(v, cnt);
        pulse_go();
        wait_starts(base + 1, 300);
        cycles(6);
        check("queued before abort", int'(queue_count), 5);
        pulse_abort();
        @(negedge clock);
        check("queue_count after abort", int'(queue_count), 0);
        cycles(40);
        check("starts after abort", starts - base, 1);
        check("no all_done after abort", adone - prev, 0);
        check("busy after abort", int'(busy), 0);
        check("moves_issued after abort", int'(moves_issued), 0);

        // Randomized batches, some appended while paused
        for (int r = 0; r < 8; r++) begin
            drv_delay = $urandom_range(1, 12);
            prev = adone;
            if (r % 3 == 2) begin
                pause = 1'b1;
                len = $urandom_range(1, 8);
                len2 = $urandom_range(1, 8);
                v = '0;
                for (int i = 0; i < len; i++) v[i*4 +: 4] = rand_any();
                v[3:0] = rand_legal();
                load_batch(v, cnt);
                pulse_go();
                v = '0;
                for (int i = 0; i < len2; i++) v[i*4 +: 4] = rand_any();
                v[3:0] = rand_legal();
                load_batch(v, cnt2);
                exp_issued = cnt + cnt2;
                cycles(3);
                pause = 1'b0;
            end else begin
                len = $urandom_range(1, 50);
                v = '0;
                for (int i = 0; i < len; i++) v[i*4 +: 4] = rand_any();
                v[3:0] = rand_legal();
                load_batch(v, cnt);
                exp_issued = cnt;
                pulse_go();
                len2 = $urandom_range(20, 80);
                for (int k = 0; k < len2; k++) begin
                    pause = ($urandom_range(0, 2) == 0);
                    cycles(1);
                end
                pause = 1'b0;
            end
            wait_done(prev, 4000);
            check("random bad_code", int'(bad_code), int'(exp_bad));
        end

        // Timeout: driver never answers
        exp_issued = -1;
        drv_respond = 1'b0;
        v = '0;
        v[3:0]  = 4'd4;
        v[7:4]  = 4'd5;
        v[11:8] = 4'd6;
        base = starts;
        load_batch(v, cnt);
        pulse_go();
        wait_starts(base + 1, 300);
        t0 = last_start;
        b = 300;
        while (!fault && b > 0) begin
            @(negedge clock);
            b--;
        end
        check("fault latency", cyc - t0, 100);
        cycles(20);
        check("fault busy", int'(busy), 0);
        check("starts while faulted", starts - base, 1);
        check("queue held while faulted", int'(queue_count), 2);
        pulse_abort();
        @(negedge clock);
        check("queue_count after fault abort", int'(queue_count), 0);
        check("fault sticky over abort", int'(fault), 1);
        cycles(5);
        check("busy after fault abort", int'(busy), 0);

        // Reset clears fault; then reset again in the middle of a settle
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        exp_bad = 1'b0;
        expq.delete();
        cycles(1);
        check("fault after reset", int'(fault), 0);
        drv_respond = 1'b1;
        drv_delay = 3;
        v = '0;
        v[3:0] = 4'd7;
        v[7:4] = 4'd8;
        base = starts;
        load_batch(v, cnt);
        pulse_go();
        wait_starts(base + 1, 300);
        repeat (5) @(posedge clock);
        #2;
        check("busy during settle", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        expq.delete();
        cycles(3);
        reset = 1'b0;
        cycles(30);
        check("no starts after reset", starts - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
